multicycle_control: RTL

- Multi-cycle successor to the single-cycle control decoder of the 8-bit Harvard core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Waits on a data-memory ready handshake, so variable-latency data memory can be used.
- Counts retired instructions.
- Drives the datapath enables: PC, IR, register file, ALU mux, data memory.

---
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the 8-bit Harvard core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, waits on data-memory ready and counts
// retired instructions.
// Build option: CONTROL_ILLEGAL_TRAP_EN sends illegal opcodes to a latched TRAP
// state; without it an illegal opcode retires as a NOP.
module multicycle_control #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic [ALUOP_W-1:0]  op,
    output logic                mread,
    output logic                mwrite,
    output logic                alusrc,
    output logic                rdt,
    output logic                mtr,
    output logic                rwrite,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic [1:0]          pc_src,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    // Zero-extension makes any opcode with bits above [5:0] set fail every match.
    localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OPC_LOAD  = OPCODE_W'(6'b100000);
    localparam logic [OPCODE_W-1:0] OPC_STORE = OPCODE_W'(6'b100001);
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(6'b100010);
    localparam logic [OPCODE_W-1:0] OPC_ADDI  = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OPC_JUMP  = OPCODE_W'(6'b010000);
    localparam logic [OPCODE_W-1:0] OPC_HALT  = OPCODE_W'(6'b010001);

    state_t                state, state_next;
    logic [OPCODE_W-1:0]   opc_q;
    logic                  retire_c;
    logic [1:0]            alu_c;
    logic                  is_r, is_ld, is_st, is_beq, is_addi, is_jmp, is_halt;
`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic                  trap_c;
`endif

    // Opcode class decode from the latched opcode only
    assign is_r    = (opc_q == OPC_RTYPE);
    assign is_ld   = (opc_q == OPC_LOAD);
    assign is_st   = (opc_q == OPC_STORE);
    assign is_beq  = (opc_q == OPC_BEQ);
    assign is_addi = (opc_q == OPC_ADDI);
    assign is_jmp  = (opc_q == OPC_JUMP);
    assign is_halt = (opc_q == OPC_HALT);

    assign op = ALUOP_W'(alu_c);
`ifdef CONTROL_ILLEGAL_TRAP_EN
    assign illegal = trap_c;
`else
    assign illegal = 1'b0;
`endif

    // State, latched opcode (captured on the edge entering DECODE) and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            opc_q       <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH) begin
                opc_q <= opcode;
            end
            if (retire_c) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Next-state and Moore outputs; everything forced low while rst is high
    always_comb begin
        state_next = state;
        retire_c   = 1'b0;
        alu_c      = 2'b00;
        mread      = 1'b0;
        mwrite     = 1'b0;
        alusrc     = 1'b0;
        rdt        = 1'b0;
        mtr        = 1'b0;
        rwrite     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        halted     = 1'b0;
`ifdef CONTROL_ILLEGAL_TRAP_EN
        trap_c     = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_jmp) begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    retire_c   = 1'b1;
                    state_next = S_FETCH;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else if (is_r || is_ld || is_st || is_beq || is_addi) begin
                    state_next = S_EXEC;
                end else begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    state_next = S_TRAP;
`else
                    retire_c   = 1'b1;
                    state_next = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_c      = 2'b10;
                    state_next = S_WB;
                end else if (is_beq) begin
                    alu_c      = 2'b01;
                    branch     = 1'b1;
                    pc_src     = 2'b01;
                    retire_c   = 1'b1;
                    state_next = S_FETCH;
                end else if (is_ld || is_st) begin
                    alusrc     = 1'b1;
                    state_next = S_MEM;
                end else begin
                    alusrc     = 1'b1;
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                mread  = is_ld;
                mwrite = !is_ld;
                if (mem_ready) begin
                    if (is_ld) begin
                        state_next = S_WB;
                    end else begin
                        retire_c   = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rwrite     = 1'b1;
                rdt        = is_r;
                mtr        = is_ld;
                retire_c   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_TRAP: begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                halted = 1'b1;
                trap_c = 1'b1;
`else
                state_next = S_FETCH;
`endif
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
        if (rst) begin
            retire_c = 1'b0;
            alu_c    = 2'b00;
            mread    = 1'b0;
            mwrite   = 1'b0;
            alusrc   = 1'b0;
            rdt      = 1'b0;
            mtr      = 1'b0;
            rwrite   = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
            branch   = 1'b0;
            pc_src   = 2'b00;
            halted   = 1'b0;
`ifdef CONTROL_ILLEGAL_TRAP_EN
            trap_c   = 1'b0;
`endif
        end
    end

endmodule
